atomik_stream_acc_engine: RTL

//   Byte-stream command engine with N_BANKS round-robin XOR delta banks and width-generic state (DELTA_WIDTH).

---
 rtl/atomik_stream_acc_engine.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/atomik_stream_acc_engine.sv
// Byte-stream command engine: load/accumulate/clear XOR deltas across round-robin banks,
// with readback of state, count, status and individual banks over a valid/ready tx port.
module atomik_stream_acc_engine #(
  parameter int DELTA_WIDTH    = 64,
  parameter int N_BANKS        = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [DELTA_WIDTH-1:0] current_state,
  output logic                   acc_zero,
  output logic [31:0]            delta_count,
  output logic                   busy,
  output logic                   err_pulse
);
  localparam int DW    = DELTA_WIDTH;
  localparam int NB    = DW / 8;
  localparam int PTR_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam int TXW   = (DW > 32) ? DW : 32;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic [5:0]  NB_LAST = 6'(NB - 1);

  typedef enum logic [2:0] {IDLE, PAYLOAD, BLEN, BSEL, TX} state_t;

  state_t           state;
  logic [DW-1:0]    banks [N_BANKS];
  logic [DW-1:0]    init_word;
  logic [DW-1:0]    shreg;
  logic [DW-1:0]    acc_xor;
  logic [DW-1:0]    word;
  logic [DW-1:0]    bank_sel;
  logic [PTR_W-1:0] rr_ptr;
  logic [31:0]      count;
  logic [31:0]      idle_cnt;
  logic [5:0]       byte_idx;
  logic [5:0]       tx_left;
  logic [7:0]       burst_left;
  logic             load_op;
  logic [TXW-1:0]   tx_buf;
  logic             count_sat;
  logic             idx_ok;
  logic             timed_out;
  logic [3:0]       rr_nib;

  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] p);
    if (N_BANKS == 1) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (&c) ? c : c + 32'd1;
  endfunction

  always_comb begin
    acc_xor = '0;
    for (int i = 0; i < N_BANKS; i++) acc_xor = acc_xor ^ banks[i];
  end

  always_comb begin
    bank_sel = '0;
    for (int i = 0; i < N_BANKS; i++)
      if (rx_data == 8'(i)) bank_sel = banks[i];
  end

  // The word completing on this byte; used directly so the write lands on the same edge.
  assign word          = (shreg << 8) | DW'(rx_data);
  assign current_state = init_word ^ acc_xor;
  assign acc_zero      = (acc_xor == '0);
  assign delta_count   = count;
  assign busy          = (state != IDLE);
  assign tx_data       = tx_buf[TXW-1 -: 8];
  assign count_sat     = &count;
  assign idx_ok        = (rx_data < 8'(N_BANKS));
  assign timed_out     = TO_EN && (idle_cnt == TO_LAST);
  assign rr_nib        = 4'(rr_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      for (int i = 0; i < N_BANKS; i++) banks[i] <= '0;
      init_word  <= '0;
      shreg      <= '0;
      rr_ptr     <= '0;
      count      <= '0;
      idle_cnt   <= '0;
      byte_idx   <= '0;
      tx_left    <= '0;
      burst_left <= '0;
      load_op    <= 1'b0;
      tx_buf     <= '0;
      tx_valid   <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: if (rx_valid) begin
          idle_cnt <= '0;
          byte_idx <= '0;
          shreg    <= '0;
          case (rx_data)
            "L": begin load_op <= 1'b1; burst_left <= 8'd1; state <= PAYLOAD; end
            "A": begin load_op <= 1'b0; burst_left <= 8'd1; state <= PAYLOAD; end
            "B": state <= BLEN;
            "K": state <= BSEL;
            "C": begin
              for (int i = 0; i < N_BANKS; i++) banks[i] <= '0;
              count  <= '0;
              rr_ptr <= '0;
            end
            "R": begin
              tx_buf   <= TXW'(current_state) << (TXW - DW);
              tx_left  <= 6'(NB);
              tx_valid <= 1'b1;
              state    <= TX;
            end
            "N": begin
              tx_buf   <= TXW'(count) << (TXW - 32);
              tx_left  <= 6'd4;
              tx_valid <= 1'b1;
              state    <= TX;
            end
            "S": begin
              tx_buf   <= TXW'({acc_zero, count_sat, 2'b00, rr_nib}) << (TXW - 8);
              tx_left  <= 6'd1;
              tx_valid <= 1'b1;
              state    <= TX;
            end
            default: err_pulse <= 1'b1;
          endcase
        end
        PAYLOAD: begin
          if (rx_valid) begin
            idle_cnt <= '0;
            if (byte_idx == NB_LAST) begin
              byte_idx <= '0;
              shreg    <= '0;
              if (load_op) begin
                init_word <= word;
                for (int i = 0; i < N_BANKS; i++) banks[i] <= '0;
                count  <= '0;
                rr_ptr <= '0;
              end else begin
                for (int i = 0; i < N_BANKS; i++)
                  if (i == int'(rr_ptr)) banks[i] <= banks[i] ^ word;
                rr_ptr <= rr_next(rr_ptr);
                count  <= sat_inc(count);
              end
              burst_left <= burst_left - 8'd1;
              if (burst_left == 8'd1) state <= IDLE;
            end else begin
              byte_idx <= byte_idx + 6'd1;
              shreg    <= word;
            end
          end else if (timed_out) begin
            state     <= IDLE;
            err_pulse <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
        end
        BLEN: begin
          if (rx_valid) begin
            idle_cnt <= '0;
            if (rx_data == 8'd0) begin
              state <= IDLE;
            end else begin
              burst_left <= rx_data;
              load_op    <= 1'b0;
              byte_idx   <= '0;
              shreg      <= '0;
              state      <= PAYLOAD;
            end
          end else if (timed_out) begin
            state     <= IDLE;
            err_pulse <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
        end
        BSEL: begin
          if (rx_valid) begin
            idle_cnt <= '0;
            if (idx_ok) begin
              tx_buf  <= TXW'(bank_sel) << (TXW - DW);
              tx_left <= 6'(NB);
            end else begin
              tx_buf    <= TXW'(8'hEE) << (TXW - 8);
              tx_left   <= 6'd1;
              err_pulse <= 1'b1;
            end
            tx_valid <= 1'b1;
            state    <= TX;
          end else if (timed_out) begin
            state     <= IDLE;
            err_pulse <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
        end
        TX: begin
          if (rx_valid) err_pulse <= 1'b1;
          if (tx_valid && tx_ready) begin
            tx_buf  <= tx_buf << 8;
            tx_left <= tx_left - 6'd1;
            if (tx_left == 6'd1) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
